// File: rtl/mux4.sv
// Registered 4-to-1 word multiplexer for MIPS operand and write-back select paths.
// One clock of latency from control/data sample to ou; synchronous active-low reset.
module mux4 #(
    parameter int unsigned           WIDTH     = 32,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       control,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] ou
);

    // An X/Z select falls into the default leg so simulation shows all-X rather than a
    // silently chosen input; synthesis is free to treat the case as full.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ou <= RESET_VAL;
        end else begin
            case (control)
                2'b00:   ou <= A;
                2'b01:   ou <= B;
                2'b10:   ou <= C;
                2'b11:   ou <= D;
                default: ou <= 'x;
            endcase
        end
    end

endmodule

// File: tb/tb_mux4.sv
// Self-checking bench for mux4: directed scenarios plus randomized traffic against a
// table-lookup reference model.
module tb_mux4;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic [1:0]       control;
    logic [WIDTH-1:0] A, B, C, D;
    logic [WIDTH-1:0] ou;

    int unsigned pass_cnt  = 0;
    int unsigned total_cnt = 0;

    mux4 #(
        .WIDTH     (WIDTH),
        .RESET_VAL ('0)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .control (control),
        .A       (A),
        .B       (B),
        .C       (C),
        .D       (D),
        .ou      (ou)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: the registered word is the input named by the select code, or zero in reset.
    function automatic logic [WIDTH-1:0] model(input logic rst, input logic [1:0] sel,
                                               input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] words [4];
        words[0] = a;
        words[1] = b;
        words[2] = c;
        words[3] = d;
        if (!rst) return '0;
        return words[sel];
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; control = 2'b11;
        A = 32'd1; B = 32'd2; C = 32'd3; D = 32'd4;
        for (int i = 0; i < 2; i++) begin
            tick();
            total_cnt++;
            if (ou !== 32'h0) $display("FAIL reset_edge%0d: got %h want %h", i, ou, 32'h0);
            else pass_cnt++;
        end
        rst_n = 1'b1;
    endtask

    task automatic test_walk();
        logic [WIDTH-1:0] prev;
        A = 32'd1; B = 32'd2; C = 32'd3; D = 32'd4;
        for (int i = 0; i < 4; i++) begin
            prev = ou;
            control = 2'(i);
            #2;
            total_cnt++;
            if (ou !== prev) $display("FAIL walk_no_comb%0d: got %h want %h", i, ou, prev);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (ou !== 32'(i + 1)) $display("FAIL walk_sel%0d: got %h want %h", i, ou, 32'(i + 1));
            else pass_cnt++;
        end
    endtask

    task automatic test_data_change();
        control = 2'b10; C = 32'd3;
        tick();
        total_cnt++;
        if (ou !== 32'd3) $display("FAIL data_before: got %h want %h", ou, 32'd3);
        else pass_cnt++;
        #2 C = 32'hDEAD_BEEF;
        #1;
        total_cnt++;
        if (ou !== 32'd3) $display("FAIL data_midcycle: got %h want %h", ou, 32'd3);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (ou !== 32'hDEAD_BEEF) $display("FAIL data_after: got %h want %h", ou, 32'hDEAD_BEEF);
        else pass_cnt++;
    endtask

    task automatic test_full_width();
        A = 32'hFFFF_FFFF; B = 32'h8000_0001;
        control = 2'b00;
        tick();
        total_cnt++;
        if (ou !== 32'hFFFF_FFFF) $display("FAIL width_a: got %h want %h", ou, 32'hFFFF_FFFF);
        else pass_cnt++;
        control = 2'b01;
        tick();
        total_cnt++;
        if (ou !== 32'h8000_0001) $display("FAIL width_b: got %h want %h", ou, 32'h8000_0001);
        else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        A = 32'd1; B = 32'd2; C = 32'd3; D = 32'd4;
        control = 2'b11;
        tick();
        total_cnt++;
        if (ou !== 32'd4) $display("FAIL midrst_pre: got %h want %h", ou, 32'd4);
        else pass_cnt++;
        rst_n = 1'b0; control = 2'b01;
        tick();
        total_cnt++;
        if (ou !== 32'd0) $display("FAIL midrst_clear: got %h want %h", ou, 32'd0);
        else pass_cnt++;
        rst_n = 1'b1;
        tick();
        total_cnt++;
        if (ou !== 32'd2) $display("FAIL midrst_resume: got %h want %h", ou, 32'd2);
        else pass_cnt++;
    endtask

    task automatic test_glitch();
        A = 32'd1; B = 32'd2; C = 32'd3; D = 32'd4;
        control = 2'b10;
        tick();
        for (int i = 0; i < 2; i++) begin
            #1 control = 2'b00;
            #1 control = 2'b11;
        end
        #1 control = 2'b01;
        #1;
        total_cnt++;
        if (ou !== 32'd3) $display("FAIL glitch_hold: got %h want %h", ou, 32'd3);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (ou !== 32'd2) $display("FAIL glitch_final: got %h want %h", ou, 32'd2);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] exp;
        for (int i = 0; i < 300; i++) begin
            rst_n   = ($urandom_range(0, 7) != 0);
            control = 2'($urandom_range(0, 3));
            A = $urandom; B = $urandom; C = $urandom; D = $urandom;
            exp = model(rst_n, control, A, B, C, D);
            tick();
            total_cnt++;
            if (ou !== exp) $display("FAIL random%0d: got %h want %h", i, ou, exp);
            else pass_cnt++;
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; control = 2'b00;
        A = '0; B = '0; C = '0; D = '0;
        #2;
        test_reset();
        test_walk();
        test_data_change();
        test_full_width();
        test_mid_reset();
        test_glitch();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
